// File: rtl/bambu_minmem_pkg.sv
// Shared definitions for the minimal memory interface: FSM state encoding and
// the access-size to data-mask helper used by master and slave-side models.
package bambu_minmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mm_state_t;

  localparam int unsigned MASK_MAX_W = 64;

  // Low 'size' bits set; callers truncate to their own data width.
  function automatic logic [MASK_MAX_W-1:0] mask_of(input int unsigned size);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      if (i < size) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/minmem_master_port.sv
// Single-channel minimal-memory-interface initiator: one command in, one bus
// transaction, one response out. Optional ACCESS timeout: MINMEM_TIMEOUT_EN.
module minmem_master_port
  import bambu_minmem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SIZE_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);

  if (SIZE_W < $clog2(DATA_W + 1)) begin : g_size_w_check
    $error("SIZE_W too narrow to hold DATA_W");
  end
  if (DATA_W > MASK_MAX_W || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("DATA_W or TIMEOUT_CYCLES out of range");
  end

  mm_state_t         state, state_next;
  logic              ready_q;
  logic              accept;
  logic              timeout_hit;
  logic [SIZE_W-1:0] size_eff;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign size_eff  = (req_size > SIZE_W'(DATA_W)) ? SIZE_W'(DATA_W) : req_size;
  assign accept    = req_valid && ready_q;
  assign req_ready = ready_q;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef MINMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] access_cnt;

  always_ff @(posedge clock) begin
    if (!reset || state != ST_ACCESS) access_cnt <= '0;
    else                              access_cnt <= access_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == ST_ACCESS) && !M_DataRdy &&
                       (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = (req_size == '0) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (M_DataRdy || timeout_hit) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ready is registered so it stays low through the reset cycle itself.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      Mout_oe_ram        <= 1'b0;
      Mout_we_ram        <= 1'b0;
      Mout_addr_ram      <= '0;
      Mout_Wdata_ram     <= '0;
      Mout_data_ram_size <= '0;
      rdata_q            <= '0;
      err_q              <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rdata_q <= '0;
            if (req_size == '0) begin
              err_q <= 1'b1;
            end else begin
              err_q              <= 1'b0;
              Mout_oe_ram        <= ~req_we;
              Mout_we_ram        <= req_we;
              Mout_addr_ram      <= req_addr;
              Mout_Wdata_ram     <= req_we ? req_wdata : '0;
              Mout_data_ram_size <= size_eff;
            end
          end
        end
        ST_ACCESS: begin
          if (M_DataRdy || timeout_hit) begin
            Mout_oe_ram        <= 1'b0;
            Mout_we_ram        <= 1'b0;
            Mout_addr_ram      <= '0;
            Mout_Wdata_ram     <= '0;
            Mout_data_ram_size <= '0;
            rdata_q <= (Mout_oe_ram && M_DataRdy) ?
                       (M_Rdata_ram & DATA_W'(mask_of(32'(Mout_data_ram_size)))) : '0;
            err_q   <= ~M_DataRdy;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
